seg_text_buffer: RTL and testbench
==================================

SEG_TEXT_BUFFER -- requirements
Module: seg_text_buffer

Interface
REQ-001 Parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (legal range 2 to 2^25-1).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 wr_valid  input  1  write request qualifier.
REQ-005 wr_ready  output  1  block can accept a write this cycle.
REQ-006 wr_mode  input  1  0 = write at wr_index, 1 = shift-in.
REQ-007 wr_index  input  3  target entry for wr_mode=0.
REQ-008 wr_char  input  5  character code: 0-15 hex digit, 16 blank, 17 dash, 18-31 blank.
REQ-009 clear  input  1  single-cycle request to blank all entries.
REQ-010 blink_en  input  1  enable blinking of one entry.
REQ-011 blink_sel  input  3  entry index to blink.
REQ-012 digit0..digit7  output  7 each  active-high segment patterns, bit6..bit0 = a,b,c,d,e,f,g; these drive the seven-segment scanner's digit inputs directly.

Function
REQ-013 The block SHALL hold an 8-entry x 5-bit character buffer; entry i drives digit<i>.
REQ-014 A write SHALL be accepted in a cycle only when wr_valid and wr_ready are both high.
REQ-015 wr_ready SHALL equal (state==IDLE) and not clear; it is combinational from state and clear only, never from wr_valid.
REQ-016 Accepted write with wr_mode=0: entry[wr_index] <= wr_char at that edge; other entries unchanged.
REQ-017 Accepted write with wr_mode=1: entry[i+1] <= entry[i] for i=0..6, entry[0] <= wr_char, old entry[7] discarded.
REQ-018 The FSM SHALL have states IDLE and CLEAR, plus a 3-bit clear index.
REQ-019 IDLE + clear=1: go to CLEAR, clear index <= 0; any write in that cycle is not accepted.
REQ-020 In CLEAR, each cycle: entry[clear index] <= 16 (blank) and the index increments. After blanking entry 7, the FSM returns to IDLE, so CLEAR lasts exactly 8 cycles.
REQ-021 clear=1 while in CLEAR SHALL restart the clear index at 0 (CLEAR extended).
REQ-022 digit<i> SHALL be a registered output, updated one edge after the entry changes (accepted write at edge k -> digit visible after edge k+1).
REQ-023 Decode: 0-15 to the standard hex patterns (0=1111110, 1=0110000, ..., F=1000111); 17 to 0000001; all other codes to 0000000.
REQ-024 Blink counter: counts 0..BLINK_DIV-1 and wraps to 0; blink phase toggles on each wrap.
REQ-025 When blink_en=1 and phase=1, digit[blink_sel] SHALL register 0000000. All other digits, and all digits when blink_en=0, show their decoded value.
REQ-026 Blink counter and phase SHALL free-run regardless of blink_en, writes or CLEAR.

Reset
REQ-027 While rst=1: state=IDLE, clear index=0, all entries=16, blink counter=0, phase=0, all digit outputs=0000000, and wr_ready=0.
REQ-028 rst asserted in the middle of CLEAR or of a write SHALL abort the operation; after release the block is in the REQ-027 state and wr_ready=1 in the first cycle.

Structure
REQ-029 Character-code constants (blank=16, dash=17) and the 16-entry hex-to-segment table SHALL live in a shared seven-segment package, reused by the scanner.
REQ-030 Decode SHALL be one sub-module, seg_char_decode (5-bit code in, 7-bit pattern out, purely combinational), instantiated 8 times.

Verification
REQ-031 Reset release, no writes -> wr_ready=1, all digits 0000000.
REQ-032 Index writes of 1, A, 17 to entries 0, 3, 7 -> after 2 edges: digit0=0110000, digit3=1110111, digit7=0000001.
REQ-033 Shift-in of 0,1,...,8 (9 writes) -> digit0=8 pattern, digit7=1 pattern, 0 pattern discarded.
REQ-034 clear pulsed together with wr_valid=1 -> write not accepted, wr_ready low for exactly 8 cycles, all digits blank 1 edge after the last clear cycle; second clear at cycle 4 -> 12 cycles total.
REQ-035 BLINK_DIV=4, blink_en=1, blink_sel=2, entry2=5 -> digit2 alternates 1011011 / 0000000 every 4 cycles; others steady.
REQ-036 rst pulsed at CLEAR cycle 3 -> all state matches REQ-027; wr_ready=1 in the cycle after release.

Source files
------------

// File: rtl/seg_text_buffer_pkg.sv
// Shared seven-segment definitions: character codes, segment patterns and the
// hex-digit lookup table. Used by the text buffer and by the display scanner.
// Segment bit order everywhere is bit6..bit0 = a,b,c,d,e,f,g, active high.
package seg_text_buffer_pkg;

  localparam int NUM_DIGITS = 8;

  // Character codes above the 16 hex digits
  localparam logic [4:0] CHAR_BLANK = 5'd16;
  localparam logic [4:0] CHAR_DASH  = 5'd17;

  localparam logic [6:0] SEG_OFF  = 7'b0000000;
  localparam logic [6:0] SEG_DASH = 7'b0000001;

  // Hex digit patterns, indexed by digit value (entry 0 is the rightmost)
  localparam logic [15:0][6:0] SEG_HEX_TABLE = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/seg_char_decode.sv
// Character-code to seven-segment decoder, purely combinational.
// Ports:
//   code_i [4:0] : character code (0-15 hex, 17 dash, anything else blank)
//   seg_o  [6:0] : active-high segment pattern a..g (bit6..bit0)
module seg_char_decode
  import seg_text_buffer_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!code_i[4]) begin
      seg_o = SEG_HEX_TABLE[code_i[3:0]];
    end else if (code_i == CHAR_DASH) begin
      seg_o = SEG_DASH;
    end
  end

endmodule

// File: rtl/seg_text_buffer.sv
// Eight-character text buffer feeding a seven-segment scanner.
// Characters are written by index or shifted in at entry 0; a clear request
// blanks the buffer one entry per cycle. One selected digit can blink.
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   wr_valid/ready   : write handshake (ready is low during clear)
//   wr_mode          : 0 = write wr_char at wr_index, 1 = shift in at entry 0
//   wr_index, wr_char: write target and 5-bit character code
//   clear            : single-cycle request to blank all entries
//   blink_en/sel     : blink the selected digit
//   digit0..digit7   : registered segment patterns, a..g = bit6..bit0
module seg_text_buffer
  import seg_text_buffer_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_mode,
  input  logic [2:0] wr_index,
  input  logic [4:0] wr_char,
  input  logic       clear,
  input  logic       blink_en,
  input  logic [2:0] blink_sel,
  output logic [6:0] digit0,
  output logic [6:0] digit1,
  output logic [6:0] digit2,
  output logic [6:0] digit3,
  output logic [6:0] digit4,
  output logic [6:0] digit5,
  output logic [6:0] digit6,
  output logic [6:0] digit7
);

  localparam int              CNT_W    = 25;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

  state_e     state_q, state_d;
  logic [2:0] clr_idx_q, clr_idx_d;
  logic [4:0] entry_q [NUM_DIGITS];
  logic [4:0] entry_d [NUM_DIGITS];
  logic [6:0] seg_dec [NUM_DIGITS];
  logic [6:0] digit_q [NUM_DIGITS];
  logic [6:0] digit_d [NUM_DIGITS];
  logic [CNT_W-1:0] blink_cnt_q;
  logic             phase_q;
  logic             wr_fire;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clear) begin
          // A repeated request restarts the sweep from entry 0
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + 3'd1;
          if (clr_idx_q == 3'd7) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Ready never looks at wr_valid, so no combinational loop
  // can form through an upstream valid-depends-on-ready source.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ready = !rst && (state_q == ST_IDLE) && !clear;
  end

  assign wr_fire = wr_valid && wr_ready;

  // ---------------------------------------------------------------------------
  // Character buffer
  // ---------------------------------------------------------------------------
  always_comb begin
    entry_d = entry_q;
    if (state_q == ST_CLEAR) begin
      entry_d[clr_idx_q] = CHAR_BLANK;
    end else if (wr_fire) begin
      if (wr_mode) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) entry_d[i] = entry_q[i-1];
        entry_d[0] = wr_char;
      end else begin
        entry_d[wr_index] = wr_char;
      end
    end
  end

  // NOTE: the buffer is reset explicitly because the display must come up
  // blank; a plain storage array with no such need would be left unreset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) entry_q[i] <= CHAR_BLANK;
    end else begin
      entry_q <= entry_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Blink timebase: free-running, phase flips once per BLINK_DIV cycles
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (blink_cnt_q == CNT_LAST) begin
      blink_cnt_q <= '0;
      phase_q     <= ~phase_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decode and output registers
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_char_decode u_dec (
      .code_i (entry_q[g]),
      .seg_o  (seg_dec[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digit_d[i] = seg_dec[i];
      if (blink_en && phase_q && (blink_sel == 3'(i))) digit_d[i] = SEG_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= SEG_OFF;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit0 = digit_q[0];
  assign digit1 = digit_q[1];
  assign digit2 = digit_q[2];
  assign digit3 = digit_q[3];
  assign digit4 = digit_q[4];
  assign digit5 = digit_q[5];
  assign digit6 = digit_q[6];
  assign digit7 = digit_q[7];

endmodule

// File: tb/tb_seg_text_buffer.sv
// Self-checking bench for seg_text_buffer (BLINK_DIV = 4).
module tb_seg_text_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_mode = 1'b0;
  logic [2:0] wr_index = '0;
  logic [4:0] wr_char = '0;
  logic       clear = 1'b0;
  logic       blink_en = 1'b0;
  logic [2:0] blink_sel = '0;
  logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7;
  logic [55:0] dut_vec;

  assign dut_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  seg_text_buffer #(.BLINK_DIV(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_mode   (wr_mode),
    .wr_index  (wr_index),
    .wr_char   (wr_char),
    .clear     (clear),
    .blink_en  (blink_en),
    .blink_sel (blink_sel),
    .digit0    (d0),
    .digit1    (d1),
    .digit2    (d2),
    .digit3    (d3),
    .digit4    (d4),
    .digit5    (d5),
    .digit6    (d6),
    .digit7    (d7)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [4:0]  model_ent [8];
  logic [55:0] sb_q [$];

  typedef struct packed {
    logic       mode;
    logic [2:0] idx;
    logic [4:0] ch;
    logic [2:0] chk;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [6:0] ref_seg(input logic [4:0] c);
    case (c)
      5'd0:  return 7'b1111110;
      5'd1:  return 7'b0110000;
      5'd2:  return 7'b1101101;
      5'd3:  return 7'b1111001;
      5'd4:  return 7'b0110011;
      5'd5:  return 7'b1011011;
      5'd6:  return 7'b1011111;
      5'd7:  return 7'b1110000;
      5'd8:  return 7'b1111111;
      5'd9:  return 7'b1111011;
      5'd10: return 7'b1110111;
      5'd11: return 7'b0011111;
      5'd12: return 7'b1001110;
      5'd13: return 7'b0111101;
      5'd14: return 7'b1001111;
      5'd15: return 7'b1000111;
      5'd17: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic logic [55:0] model_vec();
    logic [55:0] v;
    for (int i = 0; i < 8; i++) v[i*7 +: 7] = ref_seg(model_ent[i]);
    return v;
  endfunction

  task automatic check(input string name, input logic [55:0] act, input logic [55:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_blank();
    for (int i = 0; i < 8; i++) model_ent[i] = 5'd16;
  endtask

  // Drive one write, predict the buffer, compare two edges later
  task automatic do_write(input logic mode, input logic [2:0] idx, input logic [4:0] ch);
    logic [55:0] exp;
    wr_valid = 1'b1;
    wr_mode  = mode;
    wr_index = idx;
    wr_char  = ch;
    #1;
    check("wr_ready_before_write", 56'(wr_ready), 56'(1));
    step();
    wr_valid = 1'b0;
    if (mode) begin
      for (int i = 7; i > 0; i--) model_ent[i] = model_ent[i-1];
      model_ent[0] = ch;
    end else begin
      model_ent[idx] = ch;
    end
    sb_q.push_back(model_vec());
    step();
    exp = sb_q.pop_front();
    check("digits_after_write", dut_vec, exp);
  endtask

  // Counts post-edge cycles with wr_ready low after a clear pulse; optionally
  // re-asserts clear in CLEAR cycle 'again_at' (0 = never).
  task automatic run_clear(input int again_at, output int lows, output logic [6:0] d0_at2);
    lows   = 0;
    d0_at2 = '0;
    clear  = 1'b1;
    step();
    clear  = 1'b0;
    for (int n = 0; n < 30 && !wr_ready; n++) begin
      lows++;
      if (lows == 2) d0_at2 = d0;
      if (lows == again_at) begin
        clear = 1'b1;
        step();
        clear = 1'b0;
      end else begin
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int          lows;
    logic [6:0]  d0_hold;
    logic [6:0]  smp [24];
    int          k;
    logic [55:0] mask;

    vecs[0] = '{1'b0, 3'd0, 5'd1,  3'd0, 7'b0110000};
    vecs[1] = '{1'b0, 3'd3, 5'd10, 3'd3, 7'b1110111};
    vecs[2] = '{1'b0, 3'd7, 5'd17, 3'd7, 7'b0000001};
    vecs[3] = '{1'b0, 3'd1, 5'd18, 3'd1, 7'b0000000};
    vecs[4] = '{1'b0, 3'd2, 5'd15, 3'd2, 7'b1000111};
    vecs[5] = '{1'b0, 3'd4, 5'd8,  3'd4, 7'b1111111};
    vecs[6] = '{1'b0, 3'd0, 5'd16, 3'd0, 7'b0000000};

    model_blank();

    // Reset state
    #12;
    check("ready_in_reset", 56'(wr_ready), 56'(0));
    check("digits_in_reset", dut_vec, 56'(0));
    rst = 1'b0;
    #1;
    check("ready_after_release", 56'(wr_ready), 56'(1));
    check("digits_after_release", dut_vec, 56'(0));
    step();

    // Table-driven index writes
    for (int v = 0; v < 7; v++) begin
      do_write(vecs[v].mode, vecs[v].idx, vecs[v].ch);
      check("vector_digit", 56'(7'(dut_vec >> (7 * int'(vecs[v].chk)))), 56'(vecs[v].exp_seg));
    end

    // Shift in 0..8: the 0 falls off the end
    for (int c = 0; c < 9; c++) do_write(1'b1, 3'd0, 5'(c));
    check("shift_digit0_is_8", 56'(d0), 56'(7'b1111111));
    check("shift_digit7_is_1", 56'(d7), 56'(7'b0110000));

    // Clear with a write attempted in the same cycle
    wr_valid = 1'b1; wr_mode = 1'b0; wr_index = 3'd0; wr_char = 5'd5;
    clear = 1'b1;
    #1;
    check("ready_low_with_clear", 56'(wr_ready), 56'(0));
    clear = 1'b0;
    #1;
    run_clear(0, lows, d0_hold);
    wr_valid = 1'b0;
    check("clear_ready_low_cycles", 56'(lows), 56'(8));
    check("write_blocked_by_clear", 56'(d0_hold), 56'(7'b1111111));
    model_blank();
    step();
    check("digits_blank_after_clear", dut_vec, model_vec());
    check("digits_blank_const", dut_vec, 56'(0));

    // Clear re-requested in CLEAR cycle 4 extends to 12 cycles
    do_write(1'b0, 3'd2, 5'd5);
    do_write(1'b0, 3'd6, 5'd17);
    run_clear(4, lows, d0_hold);
    check("extended_clear_cycles", 56'(lows), 56'(12));
    model_blank();
    step();
    check("digits_blank_after_ext_clear", dut_vec, 56'(0));

    // Blink digit 2 holding a 5, other digits steady
    do_write(1'b0, 3'd2, 5'd5);
    do_write(1'b0, 3'd1, 5'd3);
    blink_en  = 1'b1;
    blink_sel = 3'd2;
    mask = ~(56'h7F << 14);
    for (int s = 0; s < 24; s++) begin
      step();
      smp[s] = d2;
      check("blink_others_steady", dut_vec & mask, model_vec() & mask);
    end
    k = 0;
    for (int s = 1; s < 24 && k == 0; s++) if (smp[s] != smp[s-1]) k = s;
    check("blink_first_toggle_seen", 56'(k >= 1 && k <= 4), 56'(1));
    if (k >= 1 && k <= 4) begin
      check("blink_patterns", 56'(smp[k] ^ smp[k-1]), 56'(7'b1011011));
      for (int m = k; m < 24; m++)
        check("blink_period", 56'(smp[m]), 56'((((m - k) / 4) % 2 == 0) ? smp[k] : smp[k-1]));
    end
    blink_en = 1'b0;
    step();
    step();
    check("blink_off_restores", dut_vec, model_vec());

    // Reset during CLEAR cycle 3
    do_write(1'b0, 3'd6, 5'd2);
    clear = 1'b1;
    step();
    clear = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("ready_low_in_mid_reset", 56'(wr_ready), 56'(0));
    check("digits_zero_in_mid_reset", dut_vec, 56'(0));
    step();
    rst = 1'b0;
    #1;
    check("ready_after_mid_reset", 56'(wr_ready), 56'(1));
    model_blank();
    step();
    check("ready_stays_after_abort", 56'(wr_ready), 56'(1));
    step();
    check("digits_blank_after_abort", dut_vec, 56'(0));
    do_write(1'b0, 3'd5, 5'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
